// File: rtl/zigzag_pkg.sv
// Shared definitions for the zigzag scan / quantizer block: JPEG zigzag
// order, per-position quantization shifts and the coefficient bank states.
package zigzag_pkg;

  localparam int COEF_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // Scan position -> raster address (row*8 + column) within an 8x8 block
  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Right-shift per scan position; higher frequencies are quantized harder
  localparam logic [2:0] SH_TABLE [64] = '{
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
    3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
    3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3
  };

endpackage

// File: rtl/zz_bank_ctrl.sv
// Ping-pong bank controller: tracks the state of both coefficient banks,
// the fill/drain bank pointers and the row counter of the bank being filled.
module zz_bank_ctrl
  import zigzag_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       out_ready,
  input  logic       scan_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic       fill_bank,
  output logic       drain_bank,
  output logic [2:0] row_idx
);

  bank_state_t state [2];
  bank_state_t state_nxt [2];
  logic        fill_ptr;
  logic        fill_ptr_nxt;
  logic        drain_ptr;
  logic        drain_ptr_nxt;
  logic [2:0]  row_cnt;
  logic [2:0]  row_cnt_nxt;
  logic        fill_xfer;
  logic        drain_done;

  assign fill_xfer  = in_valid && in_ready;
  assign drain_done = out_valid && out_ready && scan_last;

  // State register: bank states, pointers and row counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state[0]  <= BANK_EMPTY;
      state[1]  <= BANK_EMPTY;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      row_cnt   <= 3'd0;
    end else begin
      state[0]  <= state_nxt[0];
      state[1]  <= state_nxt[1];
      fill_ptr  <= fill_ptr_nxt;
      drain_ptr <= drain_ptr_nxt;
      row_cnt   <= row_cnt_nxt;
    end
  end

  // Next state: apply drain completion and fill progress independently, then
  // promote a full bank to draining as soon as no bank is draining
  always_comb begin
    state_nxt[0]  = state[0];
    state_nxt[1]  = state[1];
    fill_ptr_nxt  = fill_ptr;
    drain_ptr_nxt = drain_ptr;
    row_cnt_nxt   = row_cnt;
    if (drain_done) begin
      state_nxt[drain_ptr] = BANK_EMPTY;
      drain_ptr_nxt        = ~drain_ptr;
    end
    if (fill_xfer) begin
      row_cnt_nxt = row_cnt + 3'd1;
      if (row_cnt == 3'd7) begin
        state_nxt[fill_ptr] = BANK_FULL;
        fill_ptr_nxt        = ~fill_ptr;
      end else begin
        state_nxt[fill_ptr] = BANK_FILLING;
      end
    end
    if ((state_nxt[0] != BANK_DRAINING) && (state_nxt[1] != BANK_DRAINING) &&
        (state_nxt[drain_ptr_nxt] == BANK_FULL)) begin
      state_nxt[drain_ptr_nxt] = BANK_DRAINING;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready   = (state[fill_ptr] == BANK_EMPTY) || (state[fill_ptr] == BANK_FILLING);
    out_valid  = (state[drain_ptr] == BANK_DRAINING);
    fill_bank  = fill_ptr;
    drain_bank = drain_ptr;
    row_idx    = row_cnt;
  end

endmodule

// File: rtl/zigzag_quant.sv
// Zigzag reorder and shift quantizer for 8x8 DCT blocks. Rows are written into
// a ping-pong coefficient store; the drained bank is read in zigzag order and
// each coefficient is shifted right with rounding toward zero.
module zigzag_quant
  import zigzag_pkg::*;
#(
  parameter int COEF_W   = COEF_W_DEFAULT,
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*COEF_W-1:0]   in_data,
  input  logic [2:0]            in_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COEF_W-1:0]     out_coef,
  output logic [5:0]            out_idx,
  output logic                  out_last
);

  logic                     fill_bank;
  logic                     drain_bank;
  logic [2:0]               row_idx;
  logic [5:0]               scan_idx;
  logic                     scan_last;
  logic [COEF_W-1:0]        mem [128];
  logic [COEF_W-1:0]        raw_coef;
  logic [2:0]               shift;
  logic [COEF_W:0]          bias_mask;
  logic signed [COEF_W:0]   ext;
  logic signed [COEF_W:0]   addend;
  logic signed [COEF_W:0]   biased;
  logic signed [COEF_W-1:0] quant;

  assign scan_last = (scan_idx == 6'd63);

  zz_bank_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .scan_last  (scan_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .fill_bank  (fill_bank),
    .drain_bank (drain_bank),
    .row_idx    (row_idx)
  );

  // Write an accepted row into eight consecutive raster entries of the fill bank
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int c = 0; c < 8; c++) begin
        mem[{fill_bank, row_idx, 3'(c)}] <= in_data[c*COEF_W +: COEF_W];
      end
    end
  end

  // Scan index advances per accepted output and wraps after position 63
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx <= 6'd0;
    end else if (out_valid && out_ready) begin
      scan_idx <= scan_idx + 6'd1;
    end
  end

  // Zigzag read and quantization; negative values are biased so the shift truncates toward zero
  always_comb begin
    raw_coef  = mem[{drain_bank, ZZ_TABLE[scan_idx]}];
    shift     = SHIFT_EN ? SH_TABLE[scan_idx] : 3'd0;
    ext       = $signed({raw_coef[COEF_W-1], raw_coef});
    bias_mask = ~({(COEF_W+1){1'b1}} << shift);
    addend    = raw_coef[COEF_W-1] ? $signed(bias_mask) : '0;
    biased    = ext + addend;
    quant     = COEF_W'(biased >>> shift);
    out_coef  = out_valid ? quant : '0;
    out_idx   = scan_idx;
    out_last  = out_valid && scan_last;
  end

  row_order_chk: assert property (@(posedge clk) disable iff (!reset)
    (in_valid && in_ready) |-> (in_row == row_idx));

endmodule

// File: doc/zigzag_quant.md
ZIGZAG_QUANT -- requirements
Module: zigzag_quant

Interface
REQ-001 Parameter COEF_W, default 8, signed DCT coefficient width per lane.
REQ-002 Parameter SHIFT_EN, default 1; 0 bypasses quantization (all shifts forced to 0).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data holds one 8x8 block row.
REQ-006 in_ready  output  1  block accepts a row this cycle.
REQ-007 in_data  input  8*COEF_W  row of 8 signed coefficients; lane 0 in bits [COEF_W-1:0] is column 0.
REQ-008 in_row  input  3  row index of in_data; informational, checked only by assertion.
REQ-009 out_valid  output  1  out_coef/out_idx/out_last are valid.
REQ-010 out_ready  input  1  downstream run-length encoder takes the coefficient.
REQ-011 out_coef  output  COEF_W  quantized signed coefficient.
REQ-012 out_idx  output  6  zigzag scan position 0..63.
REQ-013 out_last  output  1  high with out_idx==63.

Function
REQ-014 Block SHALL hold two 64-entry coefficient banks (ping-pong); each bank is EMPTY, FILLING, FULL or DRAINING.
REQ-015 Row transfer SHALL occur on in_valid&&in_ready; row r is written to entries r*8..r*8+7 of the fill bank.
REQ-016 in_ready SHALL be high iff the current fill bank is EMPTY or FILLING.
REQ-017 A 3-bit row counter SHALL advance per transfer; after row 7 the bank becomes FULL, the counter wraps to 0 and fill moves to the other bank.
REQ-018 A FULL bank SHALL become DRAINING when no bank is draining; first out_valid asserts the cycle after the 8th row transfer when the drain side is idle.
REQ-019 Output transfer SHALL occur on out_valid&&out_ready; the 6-bit scan index increments per transfer; out_coef/out_idx SHALL hold stable while out_valid&&!out_ready.
REQ-020 out_coef SHALL be the bank entry at raster address ZZ[out_idx] (JPEG zigzag table), quantized.
REQ-021 Quantization: s = SH[out_idx] (3-bit shift table); positive values arithmetic-shift right by s; negative values add (2^s-1) before shift (round toward zero); s=0 passes through.
REQ-022 After the transfer with out_idx==63 the bank SHALL become EMPTY, index wrap to 0, and out_valid deassert unless the other bank is FULL, in which case draining continues the next cycle with no bubble.
REQ-023 Fill completing and drain completing in the same cycle SHALL both take effect; neither event is lost.
REQ-024 With both banks FULL/DRAINING, in_ready SHALL be 0; sustained throughput is one block per 64 cycles.
REQ-025 in_valid asserted while in_ready is 0 SHALL write nothing and change no state.

Reset
REQ-026 On reset low, immediately: both banks EMPTY, row counter 0, scan index 0, fill and drain pointers at bank 0, out_valid 0, out_last 0, out_coef 0, out_idx 0; in_ready 1 once reset releases.
REQ-027 Reset mid-block SHALL discard partial and pending blocks; bank contents need no clearing.

Structure
REQ-028 Shared package zigzag_pkg SHALL hold the 64-entry ZZ table, the 64-entry SH table, the bank-state encoding and the COEF_W default.
REQ-029 One sub-module, zz_bank_ctrl, SHALL own bank states and fill/drain pointers; datapath and quantizer stay in zigzag_quant.

Verification
REQ-030 Block rows with coef=r*8+c, SH all 0, out_ready=1 -> 64 outputs in order 0,1,8,16,9,2,... ending 63 with out_last=1.
REQ-031 All coefficients -9, SH[k]=2 -> out_coef -2 for every k; all +9 -> +2.
REQ-032 Two blocks back-to-back, out_ready=1 -> second block idx 0 follows first block idx 63 with no idle cycle; in_ready low while both banks busy.
REQ-033 out_ready toggled 1/0 every cycle -> 64 outputs, values stable across stalls, no duplicates or drops.
REQ-034 Reset asserted after 4 rows of block A -> out_valid 0 at once; next full block B emits only B data.
REQ-035 Third block offered while two pending -> in_ready 0 until first drain finishes; third block output intact.
